// File: rtl/memo_grid.sv
// Grid-walking robot with a register-held map, pose, saturating counters and
// a single prioritised action per cycle (load > remover > girar > avancar).
module memo_grid #(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int START_X   = 0,
    parameter int START_Y   = 0,
    parameter int START_DIR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        avancar,
    input  logic        girar,
    input  logic        remover,
    input  logic        load_en,
    input  logic [3:0]  load_x,
    input  logic [3:0]  load_y,
    input  logic [1:0]  load_cell,
    output logic        head_out,
    output logic        left_out,
    output logic        under_out,
    output logic        barrier_out,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  dir,
    output logic [15:0] step_count,
    output logic [7:0]  collision_count,
    output logic [7:0]  removed_count,
    output logic        goal_reached,
    output logic        cmd_err
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL);

    localparam logic signed [5:0] GW = 6'(GRID_W);
    localparam logic signed [5:0] GH = 6'(GRID_H);

    localparam logic [1:0] CFree = 2'b00;
    localparam logic [1:0] CWall = 2'b01;
    localparam logic [1:0] CBar  = 2'b10;
    localparam logic [1:0] CGoal = 2'b11;

    typedef logic [NCELL-1:0][1:0] map_t;

    function automatic logic in_grid(input logic signed [5:0] x, input logic signed [5:0] y);
        return (x[5] == 1'b0) && (x < GW) && (y[5] == 1'b0) && (y < GH);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic signed [5:0] x,
                                               input logic signed [5:0] y);
        logic signed [11:0] lin;
        lin = 12'(y) * 12'(GW) + 12'(x);
        return lin[IW-1:0];
    endfunction

    // Anything off the grid behaves as a wall.
    function automatic logic [1:0] rd_cell(input map_t m, input logic signed [5:0] x,
                                           input logic signed [5:0] y);
        if (!in_grid(x, y)) begin
            return CWall;
        end
        return m[cell_idx(x, y)];
    endfunction

    function automatic logic signed [5:0] step_dx(input logic [1:0] d);
        case (d)
            2'd1:    return 6'sd1;
            2'd3:    return -6'sd1;
            default: return 6'sd0;
        endcase
    endfunction

    function automatic logic signed [5:0] step_dy(input logic [1:0] d);
        case (d)
            2'd0:    return 6'sd1;
            2'd2:    return -6'sd1;
            default: return 6'sd0;
        endcase
    endfunction

    map_t        map_q, map_d;
    logic [3:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]  dir_q, dir_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  coll_q, coll_d, rem_q, rem_d;
    logic        goal_q, goal_d, err_q, err_d;

    logic signed [5:0] cx, cy, ax, ay, lx, ly, tx, ty;
    logic [1:0]        left_dir, cur_cell, ahead_cell, left_cell;
    logic              load_here;

    always_comb begin
        cx         = $signed({2'b00, pos_x_q});
        cy         = $signed({2'b00, pos_y_q});
        ax         = cx + step_dx(dir_q);
        ay         = cy + step_dy(dir_q);
        left_dir   = dir_q - 2'd1;
        lx         = cx + step_dx(left_dir);
        ly         = cy + step_dy(left_dir);
        tx         = $signed({2'b00, load_x});
        ty         = $signed({2'b00, load_y});
        load_here  = (load_x == pos_x_q) && (load_y == pos_y_q);
        cur_cell   = rd_cell(map_q, cx, cy);
        ahead_cell = rd_cell(map_q, ax, ay);
        left_cell  = rd_cell(map_q, lx, ly);
    end

    assign head_out    = (ahead_cell == CWall);
    assign barrier_out = (ahead_cell == CBar);
    assign left_out    = (left_cell == CWall);
    assign under_out   = (cur_cell == CGoal);

    always_comb begin
        map_d   = map_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_d   = dir_q;
        step_d  = step_q;
        coll_d  = coll_q;
        rem_d   = rem_q;
        goal_d  = goal_q;
        err_d   = 1'b0;

        if (load_en) begin
            err_d = avancar | girar | remover;
            if (!in_grid(tx, ty)) begin
                err_d = 1'b1;
            end else if (load_here && (load_cell == CWall || load_cell == CBar)) begin
                err_d = 1'b1;
            end else begin
                map_d[cell_idx(tx, ty)] = load_cell;
                if (load_here && load_cell == CGoal) begin
                    goal_d = 1'b1;
                end
            end
        end else if (remover) begin
            err_d = girar | avancar;
            if (barrier_out) begin
                map_d[cell_idx(ax, ay)] = CFree;
                if (rem_q != 8'hff) rem_d = rem_q + 8'd1;
            end else begin
                err_d = 1'b1;
            end
        end else if (girar) begin
            dir_d = dir_q + 2'd1;
            err_d = avancar;
        end else if (avancar) begin
            if (!head_out && !barrier_out) begin
                pos_x_d = ax[3:0];
                pos_y_d = ay[3:0];
                if (step_q != 16'hffff) step_d = step_q + 16'd1;
                if (ahead_cell == CGoal) goal_d = 1'b1;
            end else if (coll_q != 8'hff) begin
                coll_d = coll_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            map_q   <= '0;
            pos_x_q <= 4'(START_X);
            pos_y_q <= 4'(START_Y);
            dir_q   <= 2'(START_DIR);
            step_q  <= '0;
            coll_q  <= '0;
            rem_q   <= '0;
            goal_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            map_q   <= map_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            coll_q  <= coll_d;
            rem_q   <= rem_d;
            goal_q  <= goal_d;
            err_q   <= err_d;
        end
    end

    assign pos_x           = pos_x_q;
    assign pos_y           = pos_y_q;
    assign dir             = dir_q;
    assign step_count      = step_q;
    assign collision_count = coll_q;
    assign removed_count   = rem_q;
    assign goal_reached    = goal_q;
    assign cmd_err         = err_q;

endmodule

// File: tb/tb_memo_grid.sv
// Scoreboard bench for memo_grid: a grid-level reference model queues the
// expected outputs per cycle and a negedge monitor compares them.
module tb_memo_grid;

    localparam int W = 8;
    localparam int H = 8;

    logic        clock = 1'b0;
    logic        reset, avancar, girar, remover, load_en;
    logic [3:0]  load_x, load_y;
    logic [1:0]  load_cell;
    logic        head_out, left_out, under_out, barrier_out;
    logic [3:0]  pos_x, pos_y;
    logic [1:0]  dir;
    logic [15:0] step_count;
    logic [7:0]  collision_count, removed_count;
    logic        goal_reached, cmd_err;

    memo_grid #(.GRID_W(W), .GRID_H(H), .START_X(0), .START_Y(0), .START_DIR(0)) dut (
        .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
        .load_en(load_en), .load_x(load_x), .load_y(load_y), .load_cell(load_cell),
        .head_out(head_out), .left_out(left_out), .under_out(under_out),
        .barrier_out(barrier_out), .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
        .step_count(step_count), .collision_count(collision_count),
        .removed_count(removed_count), .goal_reached(goal_reached), .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int px, py, dr, h, l, u, b, sc, cc, rc, gr, err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain grid of cell codes and a pose.
    int mp[W][H];
    int mx, my, md, msc, mcc, mrc, mgr, merr;

    function automatic int mcell(int x, int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 1;
        return mp[x][y];
    endfunction

    function automatic int ddx(int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction

    function automatic int ddy(int d);
        return (d == 0) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    task automatic model_step(input bit rst, input bit av, input bit gi, input bit re,
                              input bit ld, input int lx, input int ly, input int lc);
        int ax, ay, ahead;
        if (rst) begin
            foreach (mp[i, j]) mp[i][j] = 0;
            mx = 0; my = 0; md = 0; msc = 0; mcc = 0; mrc = 0; mgr = 0; merr = 0;
            return;
        end
        merr  = 0;
        ax    = mx + ddx(md);
        ay    = my + ddy(md);
        ahead = mcell(ax, ay);
        if (ld) begin
            if (av || gi || re) merr = 1;
            if (lx >= W || ly >= H) merr = 1;
            else if (lx == mx && ly == my && (lc == 1 || lc == 2)) merr = 1;
            else begin
                mp[lx][ly] = lc;
                if (lx == mx && ly == my && lc == 3) mgr = 1;
            end
        end else if (re) begin
            if (gi || av) merr = 1;
            if (ahead == 2) begin
                mp[ax][ay] = 0;
                if (mrc < 255) mrc++;
            end else merr = 1;
        end else if (gi) begin
            md = (md + 1) % 4;
            if (av) merr = 1;
        end else if (av) begin
            if (ahead == 0 || ahead == 3) begin
                mx = ax; my = ay;
                if (msc < 65535) msc++;
                if (ahead == 3) mgr = 1;
            end else if (mcc < 255) mcc++;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   ld;
        ld    = (md + 3) % 4;
        e.px  = mx; e.py = my; e.dr = md;
        e.h   = (mcell(mx + ddx(md), my + ddy(md)) == 1);
        e.b   = (mcell(mx + ddx(md), my + ddy(md)) == 2);
        e.l   = (mcell(mx + ddx(ld), my + ddy(ld)) == 1);
        e.u   = (mcell(mx, my) == 3);
        e.sc  = msc; e.cc = mcc; e.rc = mrc; e.gr = mgr; e.err = merr;
        return e;
    endfunction

    task automatic step(input bit rst, input bit av, input bit gi, input bit re,
                        input bit ld = 0, input int lx = 0, input int ly = 0,
                        input int lc = 0);
        reset = rst; avancar = av; girar = gi; remover = re; load_en = ld;
        load_x = 4'(lx); load_y = 4'(ly); load_cell = 2'(lc);
        @(posedge clock);
        model_step(rst, av, gi, re, ld, lx, ly, lc);
        sb.push_back(model_out());
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pos_x", int'(pos_x), e.px);
            chk("pos_y", int'(pos_y), e.py);
            chk("dir", int'(dir), e.dr);
            chk("head_out", int'(head_out), e.h);
            chk("left_out", int'(left_out), e.l);
            chk("under_out", int'(under_out), e.u);
            chk("barrier_out", int'(barrier_out), e.b);
            chk("step_count", int'(step_count), e.sc);
            chk("collision_count", int'(collision_count), e.cc);
            chk("removed_count", int'(removed_count), e.rc);
            chk("goal_reached", int'(goal_reached), e.gr);
            chk("cmd_err", int'(cmd_err), e.err);
        end
    end

    initial begin
        int r;
        step(1, 0, 0, 0);
        // Straight run north on an empty grid
        repeat (3) step(0, 1, 0, 0);
        // Border collision facing west at the origin
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        // Barrier: block, clear, pass
        step(1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1, 2);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        // Turning, and a turn colliding with a move
        repeat (4) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        // Goal stickiness
        step(1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 2, 3);
        repeat (2) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        // Rejected loads: off-grid, wall under robot, load with a command
        step(0, 0, 0, 0, 1, 8, 0, 0);
        step(0, 0, 0, 0, 1, 1, 2, 1);
        step(0, 1, 0, 0, 1, 3, 3, 2);
        step(0, 0, 0, 0, 1, 2, 2, 3);
        step(0, 0, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) step(1, $urandom_range(0, 1), 0, 0);
            else if (r < 15) begin
                int c;
                c = $urandom_range(0, 99);
                c = (c < 50) ? 0 : (c < 75) ? 1 : (c < 90) ? 2 : 3;
                step(0, ($urandom_range(0, 9) == 0), 0, 0, 1,
                     $urandom_range(0, 9), $urandom_range(0, 9), c);
            end
            else if (r < 25) step(0, 0, 0, 1);
            else if (r < 45) step(0, 0, 1, 0);
            else if (r < 92) step(0, 1, 0, 0);
            else step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        // Collision counter saturation, then reset with a command held
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (256) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memo_grid.md
MEMO_GRID -- requirements
Module: memo_grid

Interface
REQ-001 Parameter GRID_W, default 8, grid width in cells (2..16).
REQ-002 Parameter GRID_H, default 8, grid height in cells (2..16).
REQ-003 Parameter START_X, default 0; START_Y, default 0; START_DIR, default 0: robot pose after reset.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 avancar  in  1  move one cell forward.
REQ-007 girar  in  1  turn 90 degrees clockwise.
REQ-008 remover  in  1  clear the barrier in the cell ahead.
REQ-009 load_en  in  1  write one map cell this cycle.
REQ-010 load_x  in  4  / load_y  in  4  target cell coordinates for load.
REQ-011 load_cell  in  2  cell code: 00 free, 01 wall, 10 barrier, 11 goal.
REQ-012 head_out  out  1  wall or grid border directly ahead.
REQ-013 left_out  out  1  wall or grid border directly to the left.
REQ-014 under_out  out  1  current cell is goal.
REQ-015 barrier_out  out  1  barrier cell directly ahead.
REQ-016 pos_x  out  4  / pos_y  out  4  / dir  out  2  current pose.
REQ-017 step_count  out  16  successful moves; collision_count  out  8  blocked avancar; removed_count  out  8  barriers cleared.
REQ-018 goal_reached  out  1  sticky; cmd_err  out  1  one-cycle pulse on rejected command.

Function
REQ-019 Directions SHALL be 0=N (y+1), 1=E (x+1), 2=S (y-1), 3=W (x-1); left of dir SHALL be (dir-1) mod 4.
REQ-020 Map SHALL be GRID_W*GRID_H cells of 2 bits held in registers; any coordinate outside the grid SHALL read as wall (01).
REQ-021 head_out, left_out, under_out, barrier_out SHALL be combinational functions of registered pose and map (zero latency after each state update).
REQ-022 Per cycle exactly one action SHALL execute, priority: load_en > remover > girar > avancar.
REQ-023 Any command (avancar/girar/remover) asserted but not executed due to priority SHALL pulse cmd_err for the following cycle.
REQ-024 load_en SHALL write load_cell to (load_x,load_y) if in range, else ignored and cmd_err pulsed; commands that cycle SHALL be dropped (with cmd_err).
REQ-025 girar SHALL set dir <= (dir+1) mod 4; position unchanged.
REQ-026 avancar with head_out=0 and barrier_out=0 SHALL move one cell in dir and increment step_count.
REQ-027 avancar with head_out=1 or barrier_out=1 SHALL leave pose unchanged and increment collision_count.
REQ-028 remover with barrier_out=1 SHALL write 00 to the cell ahead and increment removed_count; otherwise no map change and cmd_err pulsed.
REQ-029 All counters SHALL saturate at all-ones, never wrap.
REQ-030 goal_reached SHALL set on the edge where the robot enters a goal cell (or a goal is loaded under it) and hold until reset.
REQ-031 Loading a wall or barrier onto the robot's current cell SHALL be rejected with cmd_err; map unchanged.

Reset
REQ-032 On reset: pos_x=START_X, pos_y=START_Y, dir=START_DIR, all map cells 00, all counters 0, goal_reached=0, cmd_err=0.
REQ-033 Reset SHALL dominate all inputs in the same cycle; commands or loads asserted with reset SHALL be discarded without cmd_err.
REQ-034 Reset asserted mid-sequence SHALL take effect at the next edge; the following cycle behaves as fresh power-up.

Verification
REQ-035 Reset, empty 8x8, dir=0, avancar x3 -> pos=(0,3), step_count=3, head_out=0, left_out=1.
REQ-036 At (0,0) dir=3 avancar -> pose unchanged, collision_count=1, head_out=1.
REQ-037 Load barrier at (0,1), dir=0: barrier_out=1; avancar -> collision_count=1; remover -> cell=00, removed_count=1, barrier_out=0; avancar -> pos=(0,1).
REQ-038 girar x4 -> dir returns to 0; girar+avancar same cycle -> dir=1, pos unchanged, cmd_err pulses once.
REQ-039 Load goal at (0,2), avancar x2 -> under_out=1, goal_reached=1; move away -> goal_reached stays 1 until reset.
REQ-040 Force 255 collisions then one more -> collision_count stays 255; reset with avancar high -> all outputs at reset values, no cmd_err.
